issue_buffer: RTL and testbench

- Decode/issue stage directly downstream of instruction fetch.
- Each cycle `enable_pc` is high, it captures the 64-bit fetch pair (`instruction1` at PC, `instruction2` at PC+4) into a small FIFO.
- It classifies each instruction as even-pipe or odd-pipe and checks for an intra-pair dependency.
- It dual-issues or single-issues to the even and odd execution pipes, and drives `enable_pc` back to fetch.

---
 rtl/issue_buffer_if.sv | 33 +++
 rtl/issue_buffer.sv | 143 ++++++++++++++
 tb/tb_issue_buffer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/issue_buffer_if.sv
// Fetch/issue bus for issue_buffer: fetch pair and redirect in, pipe stalls in,
// fetch enable and the two issue slots out.
interface issue_buffer_if #(
  parameter int unsigned PC_W = 11
);
  logic [31:0]     instruction1;
  logic [31:0]     instruction2;
  logic            branch_flag;
  logic [PC_W-1:0] branch_target;
  logic            stall_even;
  logic            stall_odd;
  logic            enable_pc;
  logic            even_valid;
  logic [31:0]     even_instr;
  logic [PC_W-1:0] even_pc;
  logic            odd_valid;
  logic [31:0]     odd_instr;
  logic [PC_W-1:0] odd_pc;

  modport master (
    output instruction1, instruction2, branch_flag, branch_target,
           stall_even, stall_odd,
    input  enable_pc, even_valid, even_instr, even_pc,
           odd_valid, odd_instr, odd_pc
  );

  modport slave (
    input  instruction1, instruction2, branch_flag, branch_target,
           stall_even, stall_odd,
    output enable_pc, even_valid, even_instr, even_pc,
           odd_valid, odd_instr, odd_pc
  );
endinterface

// File: rtl/issue_buffer.sv
// Decode/issue stage: buffers fetched instruction pairs and dual- or
// single-issues them to the even and odd execution pipes.
module issue_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 11
) (
  input  logic           clk,
  input  logic           reset,
  issue_buffer_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     a;
    logic [31:0]     b;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            half_q, half_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            even_valid_q, even_valid_d, odd_valid_q, odd_valid_d;
  logic [31:0]     even_instr_q, even_instr_d, odd_instr_q, odd_instr_d;
  logic [PC_W-1:0] even_pc_q, even_pc_d, odd_pc_q, odd_pc_d;

  logic   enable_pc, push, pop, stalled, a_odd, b_odd, dep;
  entry_t head;

  always_comb begin
    head      = mem_q[rd_ptr_q];
    enable_pc = (count_q != FULL) && !bus.branch_flag;
    push      = enable_pc;
    stalled   = bus.stall_even || bus.stall_odd;
    a_odd     = (head.a[31:28] == 4'b0010) || (head.a[31:28] == 4'b0011);
    b_odd     = (head.b[31:28] == 4'b0010) || (head.b[31:28] == 4'b0011);
    dep       = (head.b[13:7] == head.a[6:0]) || (head.b[20:14] == head.a[6:0]);

    pop          = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    half_d       = half_q;
    pc_d         = pc_q;
    even_valid_d = even_valid_q;
    even_instr_d = even_instr_q;
    even_pc_d    = even_pc_q;
    odd_valid_d  = odd_valid_q;
    odd_instr_d  = odd_instr_q;
    odd_pc_d     = odd_pc_q;

    if (bus.branch_flag) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      half_d       = 1'b0;
      pc_d         = bus.branch_target;
      even_valid_d = 1'b0;
      odd_valid_d  = 1'b0;
    end else begin
      if (push) begin
        pc_d     = pc_q + PC_W'(8);
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      // Outputs only move on non-stalled edges; an empty FIFO just clears the valids.
      if (!stalled) begin
        even_valid_d = 1'b0;
        odd_valid_d  = 1'b0;
        if (count_q != '0) begin
          if (half_q) begin
            if (b_odd) begin
              odd_valid_d = 1'b1; odd_instr_d = head.b; odd_pc_d = head.pc + PC_W'(4);
            end else begin
              even_valid_d = 1'b1; even_instr_d = head.b; even_pc_d = head.pc + PC_W'(4);
            end
            pop    = 1'b1;
            half_d = 1'b0;
          end else begin
            if (a_odd) begin
              odd_valid_d = 1'b1; odd_instr_d = head.a; odd_pc_d = head.pc;
            end else begin
              even_valid_d = 1'b1; even_instr_d = head.a; even_pc_d = head.pc;
            end
            if ((a_odd != b_odd) && !dep) begin
              if (b_odd) begin
                odd_valid_d = 1'b1; odd_instr_d = head.b; odd_pc_d = head.pc + PC_W'(4);
              end else begin
                even_valid_d = 1'b1; even_instr_d = head.b; even_pc_d = head.pc + PC_W'(4);
              end
              pop = 1'b1;
            end else begin
              half_d = 1'b1;
            end
          end
        end
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      half_q       <= 1'b0;
      pc_q         <= '0;
      even_valid_q <= 1'b0;
      even_instr_q <= '0;
      even_pc_q    <= '0;
      odd_valid_q  <= 1'b0;
      odd_instr_q  <= '0;
      odd_pc_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      half_q       <= half_d;
      pc_q         <= pc_d;
      even_valid_q <= even_valid_d;
      even_instr_q <= even_instr_d;
      even_pc_q    <= even_pc_d;
      odd_valid_q  <= odd_valid_d;
      odd_instr_q  <= odd_instr_d;
      odd_pc_q     <= odd_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= '{pc: pc_q, a: bus.instruction1, b: bus.instruction2};
  end

  assign bus.enable_pc  = enable_pc;
  assign bus.even_valid = even_valid_q;
  assign bus.even_instr = even_instr_q;
  assign bus.even_pc    = even_pc_q;
  assign bus.odd_valid  = odd_valid_q;
  assign bus.odd_instr  = odd_instr_q;
  assign bus.odd_pc     = odd_pc_q;
endmodule

// File: tb/tb_issue_buffer.sv
// Scoreboard bench for issue_buffer: each captured pair becomes one or two
// expected issue packets; a monitor compares the outputs after every edge.
module tb_issue_buffer;
  localparam int DEPTH = 4;
  localparam int PC_W  = 11;

  typedef struct packed {
    logic            ev, od, last;
    logic [31:0]     ei, oi;
    logic [PC_W-1:0] ep, op;
  } pkt_t;

  typedef enum int {K_FLUSH, K_HOLD, K_ISSUE, K_IDLE} kind_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   failed = 0;

  pkt_t            sb[$];
  kind_t           kindq[$];
  logic [PC_W-1:0] m_pc;

  logic            x_ev, x_od;
  logic [31:0]     x_ei, x_oi;
  logic [PC_W-1:0] x_ep, x_op;

  issue_buffer_if #(.PC_W(PC_W)) bus();

  issue_buffer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_odd(input logic [31:0] i);
    return (i[31:28] == 4'h2) || (i[31:28] == 4'h3);
  endfunction

  function automatic pkt_t single(input logic [31:0] i, input logic [PC_W-1:0] pc, input bit last);
    pkt_t p = '0;
    p.last = last;
    if (is_odd(i)) begin p.od = 1'b1; p.oi = i; p.op = pc; end
    else           begin p.ev = 1'b1; p.ei = i; p.ep = pc; end
    return p;
  endfunction

  // A fetched pair issues as one dual packet or as two single packets in order.
  function automatic void add_pair(input logic [PC_W-1:0] pc, input logic [31:0] a, input logic [31:0] b);
    pkt_t pa = single(a, pc, 1'b0);
    pkt_t pb = single(b, pc + PC_W'(4), 1'b1);
    bit   dep = (b[13:7] == a[6:0]) || (b[20:14] == a[6:0]);
    if (is_odd(a) != is_odd(b) && !dep) begin
      pkt_t p = pa | pb;
      p.last = 1'b1;
      sb.push_back(p);
    end else begin
      sb.push_back(pa);
      sb.push_back(pb);
    end
  endfunction

  function automatic int pairs_pending();
    int n = 0;
    foreach (sb[i]) if (sb[i].last) n++;
    return n;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i = $urandom;
    logic [3:0]  tops [4] = '{4'h2, 4'h3, 4'h4, 4'h1};
    i[31:28] = tops[$urandom_range(0, 3)];
    i[6:0]   = 7'($urandom_range(0, 3));
    i[13:7]  = 7'($urandom_range(0, 3));
    i[20:14] = 7'($urandom_range(0, 3));
    return i;
  endfunction

  // Drive one cycle of inputs, predict fetch enable, then record what the edge must do.
  task automatic drive_cycle(input bit br, input logic [PC_W-1:0] tgt, input bit se, input bit so,
                             input logic [31:0] a, input logic [31:0] b);
    bit push_m;
    bus.branch_flag   = br;
    bus.branch_target = tgt;
    bus.stall_even    = se;
    bus.stall_odd     = so;
    bus.instruction1  = a;
    bus.instruction2  = b;
    push_m = (pairs_pending() != DEPTH) && !br;
    #1 check("enable_pc", 64'(bus.enable_pc), 64'(push_m));
    @(posedge clk);
    if (br) begin
      kindq.push_back(K_FLUSH);
      sb.delete();
      m_pc = tgt;
    end else begin
      if (se || so)          kindq.push_back(K_HOLD);
      else if (sb.size() > 0) kindq.push_back(K_ISSUE);
      else                   kindq.push_back(K_IDLE);
      if (push_m) begin
        add_pair(m_pc, a, b);
        m_pc = m_pc + PC_W'(8);
      end
    end
    @(negedge clk);
  endtask

  initial begin : monitor
    kind_t k;
    pkt_t  p;
    forever begin
      @(posedge clk);
      #1;
      if (kindq.size() != 0) begin
        k = kindq.pop_front();
        case (k)
          K_FLUSH, K_IDLE: begin x_ev = 1'b0; x_od = 1'b0; end
          K_HOLD: ;
          K_ISSUE: begin
            if (sb.size() == 0) begin
              tests++;
              failed++;
              $display("FAIL scoreboard_underflow: got issue expected empty at %0t", $time);
            end else begin
              p = sb.pop_front();
              x_ev = p.ev;
              x_od = p.od;
              if (p.ev) begin x_ei = p.ei; x_ep = p.ep; end
              if (p.od) begin x_oi = p.oi; x_op = p.op; end
            end
          end
          default: ;
        endcase
        check("even_valid", 64'(bus.even_valid), 64'(x_ev));
        check("even_instr", 64'(bus.even_instr), 64'(x_ei));
        check("even_pc",    64'(bus.even_pc),    64'(x_ep));
        check("odd_valid",  64'(bus.odd_valid),  64'(x_od));
        check("odd_instr",  64'(bus.odd_instr),  64'(x_oi));
        check("odd_pc",     64'(bus.odd_pc),     64'(x_op));
      end
    end
  end

  initial begin : stimulus
    int n;
    reset = 1'b1;
    bus.branch_flag = 1'b0; bus.branch_target = '0;
    bus.stall_even = 1'b0;  bus.stall_odd = 1'b0;
    bus.instruction1 = '0;  bus.instruction2 = '0;
    x_ev = 1'b0; x_od = 1'b0; x_ei = '0; x_oi = '0; x_ep = '0; x_op = '0;
    m_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_even_valid", 64'(bus.even_valid), 64'd0);
    check("rst_odd_valid",  64'(bus.odd_valid),  64'd0);
    check("rst_enable_pc",  64'(bus.enable_pc),  64'd1);
    check("rst_even_instr", 64'(bus.even_instr), 64'd0);
    check("rst_odd_instr",  64'(bus.odd_instr),  64'd0);
    check("rst_even_pc",    64'(bus.even_pc),    64'd0);
    check("rst_odd_pc",     64'(bus.odd_pc),     64'd0);

    // Directed pairs: dual candidate, same-pipe split, dependency split, true dual.
    drive_cycle(0, '0, 0, 0, 32'h4020_0000, 32'h3400_0000);
    drive_cycle(0, '0, 0, 0, 32'h1800_0083, 32'h1800_0105);
    drive_cycle(0, '0, 0, 0, 32'h4000_0003, 32'h3000_0180);
    drive_cycle(0, '0, 0, 0, 32'h4020_0001, 32'h3400_0000);
    repeat (6) drive_cycle(0, '0, 0, 0, rand_instr(), rand_instr());

    // Fill the buffer under an even stall, then release it.
    repeat (8) drive_cycle(0, '0, 1, 0, rand_instr(), rand_instr());
    repeat (10) drive_cycle(0, '0, 0, 0, rand_instr(), rand_instr());

    // Flush while the head pair is half issued and the odd pipe stalls.
    drive_cycle(1, '0, 0, 0, '0, '0);
    drive_cycle(0, '0, 0, 0, 32'h1800_0083, 32'h1800_0105);
    drive_cycle(0, '0, 0, 1, rand_instr(), rand_instr());
    drive_cycle(0, '0, 0, 0, rand_instr(), rand_instr());
    drive_cycle(1, 11'h040, 0, 1, rand_instr(), rand_instr());
    drive_cycle(0, '0, 0, 0, 32'h4020_0001, 32'h3400_0000);
    drive_cycle(0, '0, 0, 0, rand_instr(), rand_instr());

    for (int c = 0; c < 600; c++) begin
      bit burst = (c % 100) < 8;
      drive_cycle($urandom_range(0, 31) == 0, PC_W'($urandom),
                  burst || ($urandom_range(0, 5) == 0), $urandom_range(0, 5) == 0,
                  rand_instr(), rand_instr());
    end

    n = 0;
    while (sb.size() > 0 && n < 60) begin
      drive_cycle(0, '0, 0, 0, rand_instr(), rand_instr());
      n++;
    end
    drive_cycle(1, '0, 0, 0, '0, '0);
    drive_cycle(0, '0, 0, 0, '0, '0);
    @(posedge clk);
    #3;
    tests++;
    if (kindq.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending edges expected 0", kindq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
